// File: rtl/decode_pkg.sv
// ============================================================================
// Module : decode_pkg
// Brief  : Shared opcode encoding and control-word constants for the LC-3 decode stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package decode_pkg;

    localparam int E_W = 6;
    localparam int W_W = 2;

    typedef enum logic [3:0] {
        OP_BR   = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_LD   = 4'b0010,
        OP_ST   = 4'b0011,
        OP_JSR  = 4'b0100,
        OP_AND  = 4'b0101,
        OP_LDR  = 4'b0110,
        OP_STR  = 4'b0111,
        OP_RTI  = 4'b1000,
        OP_NOT  = 4'b1001,
        OP_LDI  = 4'b1010,
        OP_STI  = 4'b1011,
        OP_JMP  = 4'b1100,
        OP_RES  = 4'b1101,
        OP_LEA  = 4'b1110,
        OP_TRAP = 4'b1111
    } op_e;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_AND = 2'b01;
    localparam logic [1:0] ALU_NOT = 2'b10;

    localparam logic [1:0] PCSEL1_NONE = 2'b00;
    localparam logic [1:0] PCSEL1_OFF9 = 2'b01;
    localparam logic [1:0] PCSEL1_OFF6 = 2'b10;
    localparam logic [1:0] PCSEL1_BASE = 2'b11;

    localparam logic [1:0] W_ALU = 2'b00;
    localparam logic [1:0] W_PC  = 2'b01;
    localparam logic [1:0] W_MEM = 2'b10;

    typedef struct packed {
        logic [1:0] alu_ctl;
        logic [1:0] pcsel1;
        logic       pcsel2;
        logic       op2sel;
    } e_control_t;

endpackage

`default_nettype wire

// File: rtl/decode_ctrl_lut.sv
// ============================================================================
// Module : decode_ctrl_lut
// Brief  : Combinational opcode -> execute/writeback/memory control lookup.
//          Macro DECODE_ILLEGAL_OP_EN adds the illegal output.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module decode_ctrl_lut
    import decode_pkg::*;
(
    input  logic [3:0]     opcode,
    input  logic           imm_flag,
    output logic [E_W-1:0] e_ctl,
    output logic [W_W-1:0] w_ctl,
    output logic           mem_ctl
`ifdef DECODE_ILLEGAL_OP_EN
    ,
    output logic           illegal
`endif
);

    e_control_t w_e;
    logic       w_illegal;

    always_comb begin
        w_e       = '0;
        w_ctl     = W_ALU;
        mem_ctl   = 1'b0;
        w_illegal = 1'b0;
        case (op_e'(opcode))
            OP_ADD: begin
                w_e.alu_ctl = ALU_ADD;
                w_e.op2sel  = ~imm_flag;
            end
            OP_AND: begin
                w_e.alu_ctl = ALU_AND;
                w_e.op2sel  = ~imm_flag;
            end
            OP_NOT: w_e.alu_ctl = ALU_NOT;
            OP_BR, OP_ST, OP_LEA: begin
                w_e.pcsel1 = PCSEL1_OFF9;
                w_e.pcsel2 = 1'b1;
                if (op_e'(opcode) == OP_LEA) w_ctl = W_PC;
            end
            OP_LD, OP_LDI: begin
                w_e.pcsel1 = PCSEL1_OFF9;
                w_e.pcsel2 = 1'b1;
                w_ctl      = W_MEM;
                mem_ctl    = (op_e'(opcode) == OP_LDI);
            end
            OP_STI: begin
                w_e.pcsel1 = PCSEL1_OFF9;
                w_e.pcsel2 = 1'b1;
                mem_ctl    = 1'b1;
            end
            OP_JMP: w_e.pcsel1 = PCSEL1_BASE;
            OP_LDR: begin
                w_e.pcsel1 = PCSEL1_OFF6;
                w_ctl      = W_MEM;
            end
            OP_STR: w_e.pcsel1 = PCSEL1_OFF6;
            // Remaining opcodes decode to zero controls and raise the illegal flag
            default: w_illegal = 1'b1;
        endcase
    end

    assign e_ctl = w_e;

`ifdef DECODE_ILLEGAL_OP_EN
    assign illegal = w_illegal;
`else
    logic w_unused;
    assign w_unused = w_illegal;
`endif

endmodule

`default_nettype wire

// File: rtl/lc3_decode_stage.sv
// ============================================================================
// Module : lc3_decode_stage
// Brief  : LC-3 decode stage; captures IR/NPC on enable and registers the
//          decoded control words. Macro DECODE_ILLEGAL_OP_EN adds illegal_op.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module lc3_decode_stage
    import decode_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable_decode,
    input  logic [DATA_W-1:0] dout,
    input  logic [DATA_W-1:0] npc_in,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] npc_out,
    output logic [E_W-1:0]    e_control,
    output logic [W_W-1:0]    w_control,
    output logic              mem_control
`ifdef DECODE_ILLEGAL_OP_EN
    ,
    output logic              illegal_op
`endif
);

    logic [E_W-1:0]    w_e_ctl;
    logic [W_W-1:0]    w_w_ctl;
    logic              w_mem_ctl;

    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_npc;
    logic [E_W-1:0]    r_e_ctl;
    logic [W_W-1:0]    r_w_ctl;
    logic              r_mem_ctl;

`ifdef DECODE_ILLEGAL_OP_EN
    logic w_illegal;
    logic r_illegal;
`endif

    decode_ctrl_lut u_lut (
        .opcode   (dout[DATA_W-1 -: 4]),
        .imm_flag (dout[5]),
        .e_ctl    (w_e_ctl),
        .w_ctl    (w_w_ctl),
        .mem_ctl  (w_mem_ctl)
`ifdef DECODE_ILLEGAL_OP_EN
        ,
        .illegal  (w_illegal)
`endif
    );

    // Idle cycles simply hold the last decoded word; no bubble is inserted.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ir      <= '0;
            r_npc     <= '0;
            r_e_ctl   <= '0;
            r_w_ctl   <= '0;
            r_mem_ctl <= 1'b0;
        end else if (enable_decode) begin
            r_ir      <= dout;
            r_npc     <= npc_in;
            r_e_ctl   <= w_e_ctl;
            r_w_ctl   <= w_w_ctl;
            r_mem_ctl <= w_mem_ctl;
        end
    end

`ifdef DECODE_ILLEGAL_OP_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            r_illegal <= 1'b0;
        end else if (enable_decode) begin
            r_illegal <= w_illegal;
        end
    end

    assign illegal_op = r_illegal;
`endif

    assign ir          = r_ir;
    assign npc_out     = r_npc;
    assign e_control   = r_e_ctl;
    assign w_control   = r_w_ctl;
    assign mem_control = r_mem_ctl;

endmodule

`default_nettype wire

// File: tb/tb_lc3_decode_stage.sv
// ============================================================================
// Module : tb_lc3_decode_stage
// Brief  : Scoreboard bench for lc3_decode_stage (DECODE_ILLEGAL_OP_EN aware).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_lc3_decode_stage;

    typedef struct packed {
        logic [15:0] ir;
        logic [15:0] npc;
        logic [5:0]  e;
        logic [1:0]  w;
        logic        mem;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable_decode = 1'b0;
    logic [15:0] dout = '0;
    logic [15:0] npc_in = '0;
    logic [15:0] ir;
    logic [15:0] npc_out;
    logic [5:0]  e_control;
    logic [1:0]  w_control;
    logic        mem_control;
    logic        ill_bit;

    exp_t        sb[$];
    exp_t        last_exp = '0;
    exp_t        exp_v;
    exp_t        got;
    int          n_checks = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    lc3_decode_stage dut (
        .clock         (clk),
        .reset         (reset),
        .enable_decode (enable_decode),
        .dout          (dout),
        .npc_in        (npc_in),
        .ir            (ir),
        .npc_out       (npc_out),
        .e_control     (e_control),
        .w_control     (w_control),
        .mem_control   (mem_control)
`ifdef DECODE_ILLEGAL_OP_EN
        ,
        .illegal_op    (ill_bit)
`endif
    );

`ifndef DECODE_ILLEGAL_OP_EN
    assign ill_bit = 1'b0;
`endif

    function automatic exp_t model(input logic [15:0] d, input logic [15:0] n);
        exp_t r;
        int   op;
        r     = '0;
        r.ir  = d;
        r.npc = n;
        op    = int'(d[15:12]);
        if (op == 1)                                  r.e = {5'b00000, ~d[5]};
        else if (op == 5)                             r.e = {5'b01000, ~d[5]};
        else if (op == 9)                             r.e = 6'b100000;
        else if (op inside {0, 2, 3, 10, 11, 14})     r.e = 6'b000110;
        else if (op == 12)                            r.e = 6'b001100;
        else if (op inside {6, 7})                    r.e = 6'b001000;
`ifdef DECODE_ILLEGAL_OP_EN
        else                                          r.ill = 1'b1;
`endif
        if (op inside {2, 6, 10}) r.w = 2'b10;
        else if (op == 14)        r.w = 2'b01;
        r.mem = (op == 10) || (op == 11);
        return r;
    endfunction

    // Drive one cycle, push the expected post-edge state, and wait past the edge.
    task automatic drive(input logic rst, input logic en, input logic [15:0] d, input logic [15:0] n);
        @(negedge clk);
        reset         = rst;
        enable_decode = en;
        dout          = d;
        npc_in        = n;
        if (rst)     last_exp = '0;
        else if (en) last_exp = model(d, n);
        sb.push_back(last_exp);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
            exp_v = sb.pop_front();
            got   = {ir, npc_out, e_control, w_control, mem_control, ill_bit};
            n_checks++;
            if (got !== exp_v || got !== '0) begin
                n_bad++;
                $display("FAIL reset[%0d]: got %h required %h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_alu_and_ldi();
        logic [15:0] t_d[3]   = '{16'h1283, 16'h1261, 16'hA005};
        logic [15:0] t_n[3]   = '{16'h3001, 16'h3002, 16'h3003};
        logic [8:0]  t_ewm[3] = '{9'b000001_00_0, 9'b000000_00_0, 9'b000110_10_1};
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, t_d[i], t_n[i]);
            exp_v = sb.pop_front();
            got   = {ir, npc_out, e_control, w_control, mem_control, ill_bit};
            n_checks++;
            if (got !== exp_v || {e_control, w_control, mem_control} !== t_ewm[i]
                || ir !== t_d[i] || npc_out !== t_n[i]) begin
                n_bad++;
                $display("FAIL decode[%0h]: got %h required %h (ewm %b)", t_d[i], got, exp_v, t_ewm[i]);
            end
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, (i == 0), (i == 0) ? 16'h6242 : 16'hE0FF, 16'h4000 + 16'(i));
            exp_v = sb.pop_front();
            got   = {ir, npc_out, e_control, w_control, mem_control, ill_bit};
            n_checks++;
            if (got !== exp_v || e_control !== 6'b001000 || w_control !== 2'b10
                || ir !== 16'h6242 || npc_out !== 16'h4000) begin
                n_bad++;
                $display("FAIL hold[%0d]: got %h required %h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] t_d[3] = '{16'h5020, 16'h903F, 16'hC1C0};
        logic [5:0]  t_e[3] = '{6'b010000, 6'b100000, 6'b001100};
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, t_d[i], 16'h5000 + 16'(i));
            exp_v = sb.pop_front();
            got   = {ir, npc_out, e_control, w_control, mem_control, ill_bit};
            n_checks++;
            if (got !== exp_v || e_control !== t_e[i] || ir !== t_d[i]) begin
                n_bad++;
                $display("FAIL b2b[%0d]: got %h required %h (e %b)", i, got, exp_v, t_e[i]);
            end
        end
    endtask

    task automatic test_illegal_and_reset();
        logic [15:0] t_d[4] = '{16'hD000, 16'h0000, 16'h2005, 16'hF025};
        logic        t_r[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive(t_r[i], 1'b1, t_d[i], 16'h6000 + 16'(i));
            exp_v = sb.pop_front();
            got   = {ir, npc_out, e_control, w_control, mem_control, ill_bit};
            n_checks++;
            if (got !== exp_v) begin
                n_bad++;
                $display("FAIL illegal[%0d]: got %h required %h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 48; i++) begin
            drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                  16'($urandom), 16'($urandom));
            if (sb.size() == 0) begin
                n_checks++;
                n_bad++;
                $display("FAIL random[%0d]: scoreboard empty", i);
            end else begin
                exp_v = sb.pop_front();
                got   = {ir, npc_out, e_control, w_control, mem_control, ill_bit};
                n_checks++;
                if (got !== exp_v) begin
                    n_bad++;
                    $display("FAIL random[%0d]: got %h required %h", i, got, exp_v);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu_and_ldi();
        test_hold();
        test_back_to_back();
        test_illegal_and_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
